// File: rtl/tm1638_key_reader_if.sv
// Host/pad-side signal bundle of the TM1638 key reader.
interface tm1638_key_reader_if;
   logic       start;
   logic       dio_in;
   logic       stb;
   logic       sclk;
   logic       dio_out;
   logic       dio_oe;
   logic       busy;
   logic [7:0] keys;
   logic       keys_valid;

   modport master (
      output start,
      output dio_in,
      input  stb,
      input  sclk,
      input  dio_out,
      input  dio_oe,
      input  busy,
      input  keys,
      input  keys_valid
   );

   modport slave (
      input  start,
      input  dio_in,
      output stb,
      output sclk,
      output dio_out,
      output dio_oe,
      output busy,
      output keys,
      output keys_valid
   );
endinterface

// File: rtl/tm1638_key_reader.sv
// Reads the four TM1638 key-scan bytes (command 0x42) and packs the 8 panel keys.
// All pin outputs are registered from the current state, so they trail the state by one cycle.
module tm1638_key_reader #(
   parameter int HALF     = 25,
   parameter int WAIT_CYC = 50
) (
   input  logic               clki,
   input  logic               rs,
   tm1638_key_reader_if.slave bus
);
   localparam int CNT_MAX = (HALF > WAIT_CYC) ? HALF : WAIT_CYC;
   localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
   localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_CYC - 1);
   localparam logic [7:0]    CMD_READ  = 8'h42;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_CMD,
      S_WAIT,
      S_READ,
      S_END,
      S_DONE
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic          r_phase;
   logic [4:0]    r_bit;
   logic [31:0]   r_shift;
   logic          r_sample;
   logic          r_stb;
   logic          r_sclk;
   logic          r_dio_out;
   logic          r_dio_oe;
   logic          r_busy;
   logic [7:0]    r_keys;
   logic          r_keys_valid;

   logic [7:0]    w_keys;
   logic          w_half_end;
   logic          w_is_cmd;

   assign w_half_end = (r_cnt == HALF_LAST);
   assign w_is_cmd   = (r_state == S_CMD);

   // Byte i of the scan lives in r_shift[8i+7:8i]; only bits 0 and 4 carry panel keys.
   for (genvar gi = 0; gi < 4; gi++) begin : g_pack
      assign w_keys[gi]     = r_shift[8*gi];
      assign w_keys[gi + 4] = r_shift[8*gi + 4];
   end

   always_ff @(posedge clki) begin
      if (rs) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_phase      <= 1'b0;
         r_bit        <= '0;
         r_shift      <= '0;
         r_sample     <= 1'b0;
         r_stb        <= 1'b1;
         r_sclk       <= 1'b1;
         r_dio_out    <= 1'b1;
         r_dio_oe     <= 1'b0;
         r_busy       <= 1'b0;
         r_keys       <= 8'h00;
         r_keys_valid <= 1'b0;
      end else begin
         r_keys_valid <= 1'b0;
         r_sample     <= 1'b0;
         // r_sample marks the last cycle of a visible sclk-high read phase
         if (r_sample) begin
            r_shift <= {bus.dio_in, r_shift[31:1]};
         end
         case (r_state)
            S_IDLE: begin
               r_stb     <= 1'b1;
               r_sclk    <= 1'b1;
               r_dio_out <= 1'b1;
               r_dio_oe  <= 1'b0;
               r_busy    <= 1'b0;
               if (bus.start) begin
                  r_state <= S_SETUP;
                  r_cnt   <= '0;
               end
            end
            S_SETUP: begin
               r_stb     <= 1'b0;
               r_sclk    <= 1'b1;
               r_dio_out <= CMD_READ[0];
               r_dio_oe  <= 1'b1;
               r_busy    <= 1'b1;
               if (w_half_end) begin
                  r_state <= S_CMD;
                  r_cnt   <= '0;
                  r_phase <= 1'b0;
                  r_bit   <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_CMD, S_READ: begin
               r_stb     <= 1'b0;
               r_sclk    <= r_phase;
               r_dio_oe  <= w_is_cmd;
               r_dio_out <= w_is_cmd ? CMD_READ[r_bit[2:0]] : 1'b1;
               r_busy    <= 1'b1;
               r_sample  <= !w_is_cmd && r_phase && w_half_end;
               if (w_half_end) begin
                  r_cnt   <= '0;
                  r_phase <= ~r_phase;
                  if (r_phase) begin
                     if (w_is_cmd && r_bit == 5'd7) begin
                        r_state <= S_WAIT;
                        r_bit   <= '0;
                     end else if (!w_is_cmd && r_bit == 5'd31) begin
                        r_state <= S_END;
                        r_bit   <= '0;
                     end else begin
                        r_bit <= r_bit + 5'd1;
                     end
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_WAIT: begin
               r_stb     <= 1'b0;
               r_sclk    <= 1'b1;
               r_dio_out <= 1'b1;
               r_dio_oe  <= 1'b0;
               r_busy    <= 1'b1;
               if (r_cnt == WAIT_LAST) begin
                  r_state <= S_READ;
                  r_cnt   <= '0;
                  r_phase <= 1'b0;
                  r_bit   <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_END: begin
               r_stb     <= 1'b0;
               r_sclk    <= 1'b1;
               r_dio_out <= 1'b1;
               r_dio_oe  <= 1'b0;
               r_busy    <= 1'b1;
               if (w_half_end) begin
                  r_state <= S_DONE;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DONE: begin
               r_stb        <= 1'b1;
               r_sclk       <= 1'b1;
               r_dio_out    <= 1'b1;
               r_dio_oe     <= 1'b0;
               r_busy       <= 1'b0;
               r_keys       <= w_keys;
               r_keys_valid <= 1'b1;
               r_state      <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.stb        = r_stb;
   assign bus.sclk       = r_sclk;
   assign bus.dio_out    = r_dio_out;
   assign bus.dio_oe     = r_dio_oe;
   assign bus.busy       = r_busy;
   assign bus.keys       = r_keys;
   assign bus.keys_valid = r_keys_valid;
endmodule

// File: tb/tb_tm1638_key_reader.sv
// Scoreboard bench for tm1638_key_reader with a TM1638 chip model on DIO.
module tb_tm1638_key_reader;
   localparam int HALF     = 2;
   localparam int WAIT_CYC = 4;
   localparam int FRAME    = 82*HALF + WAIT_CYC;
   localparam int LAT      = FRAME + 1;

   typedef struct {
      logic [7:0] keys;
      int         cyc;
   } exp_t;

   logic        clki      = 1'b0;
   logic        rs        = 1'b1;
   logic        start_drv = 1'b0;
   logic        chip_dio  = 1'b1;
   logic [31:0] chip_word = 32'h0;
   int          rd_idx    = 0;
   int          cyc       = 0;
   int          total     = 0;
   int          bad       = 0;
   int          txn_n     = 0;
   exp_t        sb_q[$];
   exp_t        mon_e;

   tm1638_key_reader_if bus();
   assign bus.start  = start_drv;
   assign bus.dio_in = chip_dio;

   tm1638_key_reader #(.HALF(HALF), .WAIT_CYC(WAIT_CYC)) dut (
      .clki (clki),
      .rs   (rs),
      .bus  (bus)
   );

   always #5 clki = ~clki;
   always @(posedge clki) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Chip model: presents the next scan bit on each falling sclk of the read phase.
   always @(negedge bus.sclk) begin
      if (bus.stb === 1'b0 && bus.dio_oe === 1'b0) begin
         if (rd_idx < 32) chip_dio = chip_word[rd_idx];
         rd_idx++;
      end
   end

   logic [7:0] cmd_bits = 8'h0;
   int         cmd_cnt  = 0;
   always @(posedge bus.sclk) begin
      if (bus.dio_oe === 1'b1) begin
         if (cmd_cnt < 8) cmd_bits[cmd_cnt] = bus.dio_out;
         cmd_cnt++;
      end
   end
   always @(negedge bus.stb) begin
      cmd_cnt  = 0;
      cmd_bits = 8'h0;
      rd_idx   = 0;
   end

   // Scoreboard monitor
   always @(negedge clki) begin
      if (bus.keys_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_valid: keys_valid=1 keys=%02h at cycle %0d, required no pulse", bus.keys, cyc);
         end else begin
            mon_e = sb_q.pop_front();
            txn_n++;
            $display("txn %0d: keys=%02h expected %02h at cycle %0d expected %0d",
                     txn_n, bus.keys, mon_e.keys, cyc, mon_e.cyc);
            check("keys", {24'h0, bus.keys}, {24'h0, mon_e.keys});
            check("valid_cycle", cyc, mon_e.cyc);
         end
      end
   end

   // Frame length, inter-frame gap and pad contention monitor
   logic prev_stb = 1'b1;
   logic prev_oe  = 1'b0;
   logic reading  = 1'b0;
   logic in_frame = 1'b0;
   int   viol = 0, frame_len = 0, frame_starts = 0, rise_cyc = 0, last_gap = 0;
   always @(negedge clki) begin
      if (bus.stb === 1'b0 && prev_oe === 1'b1 && bus.dio_oe === 1'b0) reading = 1'b1;
      if (reading && bus.dio_oe !== 1'b0) viol++;
      if (bus.stb !== prev_stb && bus.sclk !== 1'b1) viol++;
      if (bus.stb === 1'b1) reading = 1'b0;
      if (rs) begin
         in_frame = 1'b0;
      end else if (bus.stb === 1'b0) begin
         if (!in_frame) begin
            in_frame  = 1'b1;
            frame_len = 0;
            frame_starts++;
            last_gap  = cyc - rise_cyc;
         end
         frame_len++;
      end else if (in_frame) begin
         in_frame = 1'b0;
         rise_cyc = cyc;
         check("frame_len", frame_len, FRAME);
      end
      prev_stb = bus.stb;
      prev_oe  = bus.dio_oe;
   end

   task automatic pulse_start(input logic [31:0] word, input logic [7:0] exp_keys, input bit expect_result);
      exp_t e;
      chip_word = word;
      @(posedge clki); #1 start_drv = 1'b1;
      @(posedge clki); #1 start_drv = 1'b0;
      if (expect_result) begin
         e.keys = exp_keys;
         e.cyc  = cyc + LAT;
         sb_q.push_back(e);
      end
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((sb_q.size() != 0 || bus.busy !== 1'b0) && n < 1000) begin
         @(negedge clki);
         n++;
      end
      total++;
      if (n >= 1000) begin
         bad++;
         $display("FAIL %s_timeout: busy=%b pending=%0d after %0d cycles, required completion",
                  name, bus.busy, sb_q.size(), n);
      end
      repeat (3) @(negedge clki);
   endtask

   task automatic post_checks(input logic [7:0] exp_keys);
      check("cmd_bits", {24'h0, cmd_bits}, 32'h42);
      check("cmd_edges", cmd_cnt, 8);
      check("contention", viol, 0);
      check("keys_hold", {24'h0, bus.keys}, {24'h0, exp_keys});
   endtask

   int fs0, k1;
   exp_t e2;

   initial begin
      // Reset held for three edges
      rs = 1'b1;
      repeat (3) @(posedge clki);
      #1;
      check("rst_stb", bus.stb, 1'b1);
      check("rst_sclk", bus.sclk, 1'b1);
      check("rst_dio_oe", bus.dio_oe, 1'b0);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_keys", {24'h0, bus.keys}, 32'h0);
      check("rst_keys_valid", bus.keys_valid, 1'b0);
      rs = 1'b0;

      // Bytes 01,10,00,11 -> A9
      pulse_start(32'h11_00_10_01, 8'hA9, 1'b1);
      wait_idle("t1");
      post_checks(8'hA9);

      // Bytes FF,00,EE,10 -> 91, with an ignored start mid-frame
      fs0 = frame_starts;
      pulse_start(32'h10_EE_00_FF, 8'h91, 1'b1);
      repeat (50) @(posedge clki);
      #1 start_drv = 1'b1;
      @(posedge clki); #1 start_drv = 1'b0;
      wait_idle("t2");
      check("t2_frames", frame_starts - fs0, 1);
      post_checks(8'h91);

      // start held high: exactly two frames, 2-cycle gap between them
      fs0 = frame_starts;
      chip_word = 32'h11_00_10_01;
      @(posedge clki); #1 start_drv = 1'b1;
      @(posedge clki); #1;
      k1 = cyc;
      e2.keys = 8'hA9; e2.cyc = k1 + LAT;       sb_q.push_back(e2);
      e2.keys = 8'hA9; e2.cyc = k1 + 170 + LAT; sb_q.push_back(e2);
      repeat (170) @(posedge clki);
      #1 start_drv = 1'b0;
      wait_idle("b2b");
      check("b2b_frames", frame_starts - fs0, 2);
      check("b2b_gap", last_gap, 2);
      post_checks(8'hA9);
      repeat (20) @(negedge clki);
      check("keys_idle_hold", {24'h0, bus.keys}, 32'hA9);

      // Reset during read slot 10
      pulse_start(32'hFF_FF_FF_FF, 8'h00, 1'b0);
      repeat (80) @(posedge clki);
      #1 rs = 1'b1;
      @(posedge clki); #1;
      check("midrst_stb", bus.stb, 1'b1);
      check("midrst_keys", {24'h0, bus.keys}, 32'h0);
      check("midrst_busy", bus.busy, 1'b0);
      check("midrst_dio_oe", bus.dio_oe, 1'b0);
      check("midrst_sclk", bus.sclk, 1'b1);
      repeat (2) @(posedge clki);
      #1 rs = 1'b0;

      // Bytes EE,EF,FE,01 -> 4A after the aborted frame
      pulse_start(32'h01_FE_EF_EE, 8'h4A, 1'b1);
      wait_idle("t3");
      post_checks(8'h4A);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
